// File: rtl/main_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | main_pkg                                                                   |
// | Shared widths and sequencer state type for the LNS MAC top level.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package main_pkg;

  localparam int IN_BITS  = 16;
  localparam int OUT_BITS = 32;
  localparam int LEN_BITS = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/lns_dot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lns_dot_sequencer                                                          |
// | Streams one dot-product job into the LNS MAC and keeps only the last sum.  |
// | Optional stall counter: define LNS_SEQ_STALL_CNT_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lns_dot_sequencer #(
  parameter int IN_BITS  = main_pkg::IN_BITS,
  parameter int OUT_BITS = main_pkg::OUT_BITS,
  parameter int LEN_BITS = main_pkg::LEN_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                op_valid,
  output logic                op_enable,
  input  logic [IN_BITS:0]    op_x,
  input  logic [IN_BITS:0]    op_y,
  input  logic                op_x_nat_sign,
  input  logic                op_y_nat_sign,
  output logic                mac_clr,
  output logic                mac_data_in_valid,
  input  logic                mac_data_in_enable,
  output logic [IN_BITS:0]    mac_data_in_x,
  output logic [IN_BITS:0]    mac_data_in_y,
  output logic                mac_data_in_x_nat_sign,
  output logic                mac_data_in_y_nat_sign,
  input  logic                mac_data_out_valid,
  output logic                mac_data_out_enable,
  input  logic [OUT_BITS:0]   mac_data_out,
  output logic                res_valid,
  input  logic                res_enable,
  output logic [OUT_BITS:0]   res_data,
  output logic                busy
`ifdef LNS_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  import main_pkg::*;

  localparam logic [LEN_BITS-1:0] c_len_one = LEN_BITS'(1);

  seq_state_t          r_state;
  seq_state_t          w_next_state;
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS-1:0] r_sent_cnt;
  logic [LEN_BITS-1:0] r_recv_cnt;
  logic [OUT_BITS:0]   r_res_data;
  logic                r_res_valid;

  logic w_streaming;
  logic w_collecting;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_last_in;
  logic w_last_out;
  logic w_job_accept;
  logic w_zero_job;

  assign w_streaming  = (r_state == STREAM);
  assign w_collecting = (r_state == STREAM) || (r_state == DRAIN);
  assign w_in_xfer    = w_streaming && op_valid && mac_data_in_enable;
  assign w_out_xfer   = w_collecting && mac_data_out_valid;
  assign w_last_in    = w_in_xfer && (r_sent_cnt == (r_len - c_len_one));
  assign w_last_out   = w_out_xfer && (r_recv_cnt == (r_len - c_len_one));
  assign w_job_accept = (r_state == IDLE) && start;
  assign w_zero_job   = w_job_accept && (cfg_len == '0);

  // Operand path is wired straight through so a pair costs no extra cycle.
  assign op_enable              = w_streaming && mac_data_in_enable;
  assign mac_data_in_valid      = w_streaming && op_valid;
  assign mac_data_in_x          = op_x;
  assign mac_data_in_y          = op_y;
  assign mac_data_in_x_nat_sign = op_x_nat_sign;
  assign mac_data_in_y_nat_sign = op_y_nat_sign;

  assign mac_data_out_enable = w_collecting;
  assign mac_clr             = (r_state == CLEAR);
  assign busy                = (r_state != IDLE);
  assign res_valid           = r_res_valid;
  assign res_data            = r_res_data;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (cfg_len == '0) ? OUTPUT : CLEAR;
        end
      end
      CLEAR: begin
        w_next_state = STREAM;
      end
      STREAM: begin
        // The final sum wins over the last-pair hand-off in the same cycle.
        if (w_last_out) begin
          w_next_state = OUTPUT;
        end else if (w_last_in) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_out) begin
          w_next_state = OUTPUT;
        end
      end
      OUTPUT: begin
        if (res_enable) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_sent_cnt  <= '0;
      r_recv_cnt  <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_job_accept) begin
        r_sent_cnt <= '0;
        r_recv_cnt <= '0;
        if (cfg_len != '0) begin
          r_len <= cfg_len;
        end
      end

      if (w_in_xfer) begin
        r_sent_cnt <= r_sent_cnt + c_len_one;
      end
      if (w_out_xfer) begin
        r_recv_cnt <= r_recv_cnt + c_len_one;
      end

      if (w_zero_job) begin
        r_res_data  <= '0;
        r_res_valid <= 1'b1;
      end else if (w_last_out) begin
        r_res_data  <= mac_data_out;
        r_res_valid <= 1'b1;
      end else if ((r_state == OUTPUT) && res_enable) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef LNS_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_job_accept) begin
      r_stall_cnt <= '0;
    end else if (w_streaming && op_valid && !mac_data_in_enable && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lns_dot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lns_dot_sequencer                                                       |
// | Randomized jobs against a job-level model of the sequencer and a toy MAC.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lns_dot_sequencer;
  import main_pkg::*;

  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_RUN  = 2;
  localparam int P_OUT  = 3;
  localparam int MAX_PAIRS = 1 << LEN_BITS;

  logic                clk;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [LEN_BITS-1:0] cfg_len = '0;
  logic                op_valid = 1'b0;
  logic                op_enable;
  logic [IN_BITS:0]    op_x = '0;
  logic [IN_BITS:0]    op_y = '0;
  logic                op_x_nat_sign = 1'b0;
  logic                op_y_nat_sign = 1'b0;
  logic                mac_clr;
  logic                mac_data_in_valid;
  logic                mac_data_in_enable = 1'b0;
  logic [IN_BITS:0]    mac_data_in_x;
  logic [IN_BITS:0]    mac_data_in_y;
  logic                mac_data_in_x_nat_sign;
  logic                mac_data_in_y_nat_sign;
  logic                mac_data_out_valid = 1'b0;
  logic                mac_data_out_enable;
  logic [OUT_BITS:0]   mac_data_out = '0;
  logic                res_valid;
  logic                res_enable = 1'b0;
  logic [OUT_BITS:0]   res_data;
  logic                busy;
`ifdef LNS_SEQ_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  lns_dot_sequencer dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .cfg_len                (cfg_len),
    .op_valid               (op_valid),
    .op_enable              (op_enable),
    .op_x                   (op_x),
    .op_y                   (op_y),
    .op_x_nat_sign          (op_x_nat_sign),
    .op_y_nat_sign          (op_y_nat_sign),
    .mac_clr                (mac_clr),
    .mac_data_in_valid      (mac_data_in_valid),
    .mac_data_in_enable     (mac_data_in_enable),
    .mac_data_in_x          (mac_data_in_x),
    .mac_data_in_y          (mac_data_in_y),
    .mac_data_in_x_nat_sign (mac_data_in_x_nat_sign),
    .mac_data_in_y_nat_sign (mac_data_in_y_nat_sign),
    .mac_data_out_valid     (mac_data_out_valid),
    .mac_data_out_enable    (mac_data_out_enable),
    .mac_data_out           (mac_data_out),
    .res_valid              (res_valid),
    .res_enable             (res_enable),
    .res_data               (res_data),
    .busy                   (busy)
`ifdef LNS_SEQ_STALL_CNT_EN
    ,
    .stall_cnt              (stall_cnt)
`endif
  );

  typedef struct {
    logic [OUT_BITS:0] d;
    int                rdy;
  } mac_out_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Job-level reference state
  int                phase = P_IDLE;
  int                m_len = 0;
  int                m_sent = 0;
  int                m_recv = 0;
  logic [OUT_BITS:0] m_res = '0;
  logic [31:0]       m_stall = '0;
  logic [OUT_BITS:0] job_sum;
  bit                job_started;

  // Job stimulus
  logic [IN_BITS:0]    px [MAX_PAIRS];
  logic [IN_BITS:0]    py [MAX_PAIRS];
  logic                psx [MAX_PAIRS];
  logic                psy [MAX_PAIRS];
  int                  job_len = 0;
  int                  p_idx = 0;
  bit                  prod_valid = 1'b0;
  int                  in_mode = 0;
  int                  lat = 0;
  bit                  start_req = 1'b0;
  logic [LEN_BITS-1:0] start_len = '0;
  bit                  rst_req = 1'b0;

  // Toy MAC running sum and its delayed output queue
  logic [OUT_BITS:0] acc = '0;
  mac_out_t          mq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    bit                  s_in_en;
    bit                  exp_stream;
    bit                  d_op_en;
    bit                  d_in_valid;
    bit                  d_out_en;
    bit                  d_clr;
    logic [IN_BITS:0]    d_x;
    logic [IN_BITS:0]    d_y;
    logic [3:0]          pat;
    logic [63:0]         r64;
    logic [2*IN_BITS+1:0] prod;

    @(negedge clk);
    rst       = rst_req;
    rst_req   = 1'b0;
    start     = start_req;
    cfg_len   = start_len;
    start_req = 1'b0;

    pat = 4'b1001;
    case (in_mode)
      0:       s_in_en = 1'b1;
      1:       s_in_en = pat[cyc[1:0]];
      default: s_in_en = ($urandom_range(0, 1) == 1);
    endcase
    mac_data_in_enable = s_in_en;

    if (!prod_valid && (p_idx < job_len) && ($urandom_range(0, 3) != 0)) prod_valid = 1'b1;
    op_valid = prod_valid;
    if (prod_valid) begin
      op_x = px[p_idx];
      op_y = py[p_idx];
      op_x_nat_sign = psx[p_idx];
      op_y_nat_sign = psy[p_idx];
    end else begin
      op_x = IN_BITS'($urandom());
      op_y = IN_BITS'($urandom());
      op_x_nat_sign = $urandom_range(0, 1) == 1;
      op_y_nat_sign = $urandom_range(0, 1) == 1;
    end

    r64 = {$urandom(), $urandom()};
    if ((mq.size() > 0) && (mq[0].rdy <= cyc)) begin
      mac_data_out_valid = 1'b1;
      mac_data_out = mq[0].d;
    end else if ((phase == P_IDLE) && ($urandom_range(0, 3) == 0)) begin
      mac_data_out_valid = 1'b1;   // stray sum that must not be consumed
      mac_data_out = r64[OUT_BITS:0];
    end else begin
      mac_data_out_valid = 1'b0;
      mac_data_out = r64[OUT_BITS:0];
    end
    res_enable = ($urandom_range(0, 2) == 0);

    #1;
    exp_stream = (phase == P_RUN) && (m_sent < m_len);
    check("busy", busy, phase != P_IDLE);
    check("mac_clr", mac_clr, phase == P_CLR);
    check("op_enable", op_enable, exp_stream ? s_in_en : 1'b0);
    check("mac_in_valid", mac_data_in_valid, exp_stream ? op_valid : 1'b0);
    check("mac_out_enable", mac_data_out_enable, phase == P_RUN);
    check("res_valid", res_valid, phase == P_OUT);
    check("res_data", res_data, m_res);
    if (exp_stream && op_valid && s_in_en) begin
      check("pair_x", mac_data_in_x, px[m_sent]);
      check("pair_y", mac_data_in_y, py[m_sent]);
      check("pair_sx", mac_data_in_x_nat_sign, psx[m_sent]);
      check("pair_sy", mac_data_in_y_nat_sign, psy[m_sent]);
    end else if (exp_stream) begin
      check("pass_x", mac_data_in_x, op_x);
    end
`ifdef LNS_SEQ_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    d_op_en    = op_enable;
    d_in_valid = mac_data_in_valid;
    d_out_en   = mac_data_out_enable;
    d_clr      = mac_clr;
    d_x        = mac_data_in_x;
    d_y        = mac_data_in_y;

    @(posedge clk);
    if (rst) begin
      phase = P_IDLE;
      m_res = '0;
      m_stall = '0;
      mq.delete();
      acc = '0;
      prod_valid = 1'b0;
      p_idx = job_len;
    end else begin
      if (d_clr) acc = '0;
      if (op_valid && d_op_en) begin
        p_idx++;
        prod_valid = 1'b0;
      end
      if (d_in_valid && s_in_en) begin
        prod = {{(IN_BITS+1){1'b0}}, d_x} * {{(IN_BITS+1){1'b0}}, d_y};
        acc = acc + prod[OUT_BITS:0];
        mq.push_back('{d: acc, rdy: cyc + 1 + lat});
      end
      if (mac_data_out_valid && d_out_en && (mq.size() > 0) && (mq[0].rdy <= cyc))
        void'(mq.pop_front());

      if (exp_stream && op_valid && !s_in_en && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      case (phase)
        P_IDLE: begin
          if (start) begin
            job_started = 1'b1;
            m_stall = '0;
            if (cfg_len != '0) begin
              phase = P_CLR;
              m_len = int'(cfg_len);
              m_sent = 0;
              m_recv = 0;
            end else begin
              phase = P_OUT;
              m_res = '0;
            end
          end
        end
        P_CLR: phase = P_RUN;
        P_RUN: begin
          if (op_valid && s_in_en && (m_sent < m_len)) m_sent++;
          if (mac_data_out_valid) begin
            m_recv++;
            if (m_recv == m_len) begin
              m_res = job_sum;
              phase = P_OUT;
            end
          end
        end
        default: if (res_enable) phase = P_IDLE;
      endcase
    end
    cyc++;
  endtask

  task automatic run_job(input int len, input int mode, input int lat_i,
                         input bit inj, input int abort_at);
    logic [2*IN_BITS+1:0] prod;
    bit done = 1'b0;
    bit inj_run = 1'b0;
    bit inj_out = 1'b0;
    bit aborted = 1'b0;

    job_len = len;
    job_sum = '0;
    for (int i = 0; i < len; i++) begin
      px[i]  = IN_BITS'($urandom());
      py[i]  = IN_BITS'($urandom());
      psx[i] = $urandom_range(0, 1) == 1;
      psy[i] = $urandom_range(0, 1) == 1;
      prod = {{(IN_BITS+1){1'b0}}, px[i]} * {{(IN_BITS+1){1'b0}}, py[i]};
      job_sum = job_sum + prod[OUT_BITS:0];
    end
    p_idx = 0;
    prod_valid = 1'b0;
    in_mode = mode;
    lat = lat_i;
    job_started = 1'b0;
    start_req = 1'b1;
    start_len = LEN_BITS'(len);

    for (int k = 0; (k < len * 4 + 60) && !done; k++) begin
      if (inj && (phase == P_RUN) && (m_sent >= 1) && !inj_run) begin
        start_req = 1'b1;
        start_len = LEN_BITS'(len + 3);
        inj_run = 1'b1;
      end
      if (inj && (phase == P_OUT) && !inj_out) begin
        start_req = 1'b1;
        start_len = LEN_BITS'(len + 5);
        inj_out = 1'b1;
      end
      if ((abort_at > 0) && (phase == P_RUN) && (m_sent == abort_at) && !aborted) begin
        rst_req = 1'b1;
        aborted = 1'b1;
      end
      tick();
      if (job_started && (phase == P_IDLE)) done = 1'b1;
    end
    if (!done) begin
      check("job_timeout", 64'd0, 64'd1);
      rst_req = 1'b1;
      tick();
    end
  endtask

  initial begin
    repeat (3) begin
      rst_req = 1'b1;
      tick();
    end
    repeat (2) tick();

    run_job(4, 0, 0, 1'b0, 0);     // plain job, MAC always ready
    run_job(0, 0, 0, 1'b0, 0);     // zero-length job
    run_job(3, 1, 0, 1'b0, 0);     // 1,0,0,1 back-pressure
    run_job(3, 0, 2, 1'b0, 0);     // MAC sums two cycles late
    run_job(5, 2, 1, 1'b1, 0);     // start pulses while busy
    run_job(5, 0, 0, 1'b0, 2);     // reset after two pairs
    run_job(2, 0, 0, 1'b0, 0);
    run_job(MAX_PAIRS - 1, 0, 0, 1'b0, 0);
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 8), $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, 0);
    end
    run_job(0, 2, 0, 1'b1, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
